// File: rtl/serial_addsub_64.sv
// Bit-serial adder/subtractor: one full-adder stage per cycle, LSB first.
// Valid/ready handshake on both sides; result and flags held in DONE.
module serial_addsub_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic sum_bit;
  logic c_out;
  logic last;

  assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_out   = (a_q[0] & b_q[0]) |
                   (carry_q & (a_q[0] ^ b_q[0]));
  assign last    = (state_q == RUN) &&
                   (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = RUN;
      RUN:  if (last)      state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        // carry_q here is the carry into the MSB
        if (last) begin
          cout_d = c_out;
          ovf_d  = carry_q ^ c_out;
          zero_d = (res_d == '0);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub_64.sv
// Scoreboard bench for serial_addsub_64: driver pushes expected results,
// monitor pops and compares on each output handshake.
module tb_serial_addsub_64;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  serial_addsub_64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the negedge, when driver inputs are settled
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    while (!done) begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid && q.size() > 0)
          check("latency", W'(cyc - q[0].acc), W'(W + 1));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            check("result", result, e.res);
            check("cout", W'(cout), W'(e.c));
            check("overflow", W'(overflow), W'(e.o));
            check("zero", W'(zero), W'(e.z));
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta,
                       input logic [W-1:0] tb_,
                       input logic ts,
                       input logic [W-1:0] er,
                       input logic ec, eo, ez,
                       input bit push);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    sub = ts;
    if (push) begin
      e.res = er; e.c = ec; e.o = eo; e.z = ez; e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", W'(q.size()), 0);
      q.delete();
    end
  endtask

  task automatic op(input logic [W-1:0] ta,
                    input logic [W-1:0] tb_,
                    input logic ts,
                    input logic [W-1:0] er,
                    input logic ec, eo, ez);
    issue(ta, tb_, ts, er, ec, eo, ez, 1'b1);
    drain();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    #23;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_flags", W'({cout, overflow, zero}), 0);
    @(negedge clk);
    reset = 1'b0;

    op(64'd5, 64'd3, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
       64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1,
       64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    op(64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    op(64'h1234, 64'h1234, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure with stray in_valid pulses in RUN and DONE
    out_ready = 1'b0;
    issue(64'd100, 64'd23, 1'b1, 64'd77, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("in_ready_run", W'(in_ready), 0);
    in_valid = 1'b1;
    a = 64'd999;
    b = 64'd1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", W'(out_valid), W'(1));
      check("bp_result", result, 64'd77);
      check("bp_in_ready", W'(in_ready), 0);
      in_valid = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_back_idle", W'(in_ready), W'(1));
    check("bp_valid_low", W'(out_valid), 0);
    drain();

    // Abort mid-RUN with asynchronous reset
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0,
          1'b0);
    repeat (29) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_result", result, 0);
    check("abort_out_valid", W'(out_valid), 0);
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_flags", W'({cout, overflow, zero}), 0);
    @(negedge clk);
    reset = 1'b0;
    op(64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("no_spurious_valid", W'(out_valid), 0);
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub_64.md
SERIAL_ADDSUB_64 -- requirements
Module: serial_addsub_64

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operands and op are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept operands (IDLE only).
REQ-006 The block SHALL have port a, input, WIDTH, the first operand.
REQ-007 The block SHALL have port b, input, WIDTH, the second operand.
REQ-008 The block SHALL have port sub, input, 1, where 0 selects a+b and 1 selects a-b.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result and flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH, the sum or difference modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1, the carry out of the MSB (for sub, 1 means no borrow).
REQ-013 The block SHALL have port overflow, output, 1, signed two's-complement overflow.
REQ-014 The block SHALL have port zero, output, 1, meaning result equals 0.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, the block SHALL capture a, b (b inverted when sub=1) and sub, preset the carry flip-flop to sub, clear the bit counter, and go to RUN.
REQ-017 RUN: each cycle the block SHALL add operand bit 0s and the carry in one 1-bit full-adder stage, shift the sum bit into the result MSB, shift both operand registers right by one, update the carry, and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles, after which the block SHALL go to DONE; latency is WIDTH+1 cycles from the accept edge to the first out_valid=1 cycle.
REQ-019 At the final RUN cycle the block SHALL register cout as the final carry and overflow as carry-into-MSB XOR carry-out-of-MSB.
REQ-020 DONE: out_valid=1 and result/cout/overflow/zero SHALL be held stable until out_ready=1, then the block SHALL go to IDLE on that edge.
REQ-021 in_valid SHALL be ignored in RUN and DONE; in_ready=0 in both.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 zero SHALL be derived from the final registered result and be valid whenever out_valid=1.
REQ-024 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during one operation.
REQ-025 Outputs SHALL be registered; there SHALL be no combinational path from inputs to result or flags.
REQ-026 in_ready SHALL be decoded from state only, with no dependence on in_valid.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, cout=0, overflow=0, zero=0, and clear the carry and counter, regardless of clock.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no residual output; the first accept after deassertion SHALL behave as from power-up.

Verification
REQ-029 WIDTH=64, a=5, b=3, sub=0 -> out_valid on the 65th cycle after accept, result=8, cout=0, overflow=0, zero=0.
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0, cout=1, overflow=0, zero=1.
REQ-031 a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0x8000_0000_0000_0000, overflow=1, cout=0; then a=0x8000_0000_0000_0000, b=1, sub=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1.
REQ-032 a=3, b=5, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), overflow=0; a=b=0x1234, sub=1 -> zero=1, cout=1.
REQ-033 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and result stable; in_valid pulses in RUN/DONE are ignored; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-034 Reset asserted at RUN cycle 30 -> outputs zeroed asynchronously; a new op a=1, b=1 afterwards -> result=2 with full WIDTH+1 latency.
